// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter driving the register-file write port from two sources.
//   - ALU path (alu_valid/alu_rd/alu_data): single cycle, normally has priority.
//   - LSU path (lsu_valid/lsu_ready/lsu_rd/lsu_data): buffered in a FIFO_DEPTH-entry FIFO.
// Outputs wen/wraddr/wrdata are registered, one cycle after the grant.
// An ALU write to rd kills (clears live on) every buffered entry with the same rd, so an
// older load result can never overwrite a younger ALU result. A killed head still pops,
// but with wen=0. fifo_count reports occupancy including killed entries.
// Optional feature, macro WB_STARVE_GUARD_EN: after STARVE_MAX consecutive ALU wins over a
// live FIFO head, alu_stall is raised for one cycle and the head is popped instead.
// Without the macro alu_stall is constant 0 and the ALU always wins.
// Reset: rst, asynchronous, active-high.
module wb_arbiter #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid,
   input  logic [4:0]                    alu_rd,
   input  logic [31:0]                   alu_data,
   output logic                          alu_stall,
   input  logic                          lsu_valid,
   output logic                          lsu_ready,
   input  logic [4:0]                    lsu_rd,
   input  logic [31:0]                   lsu_data,
   output logic                          wen,
   output logic [4:0]                    wraddr,
   output logic [31:0]                   wrdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_MAX < 1)
   begin : g_param_check
      $error("wb_arbiter: FIFO_DEPTH must be a power of 2 >= 2 and STARVE_MAX >= 1");
   end

   // FIFO storage; only the live bits need a reset value.
   logic [FIFO_DEPTH-1:0] live_q, live_d;
   logic [4:0]            rd_q   [FIFO_DEPTH];
   logic [31:0]           data_q [FIFO_DEPTH];
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]       count_q, count_d;

   logic                  alu_stall_q, alu_stall_d;
   logic                  wen_q, wen_d;
   logic [4:0]            wraddr_q, wraddr_d;
   logic [31:0]           wrdata_q, wrdata_d;

   logic alu_grant, pop, push, kill, fifo_full, fifo_empty, head_live;

   assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   // No pass-through: readiness depends on the registered count only.
   assign lsu_ready  = !fifo_full;
   assign head_live  = !fifo_empty && live_q[rd_ptr_q];

   assign alu_grant  = alu_valid && !alu_stall_q;
   assign pop        = !alu_grant && !fifo_empty;
   // A zero-rd LSU result completes its handshake but is dropped.
   assign push       = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
   assign kill       = alu_grant && (alu_rd != 5'd0);

   always_comb begin
      live_d   = live_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (kill) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (rd_q[i] == alu_rd) live_d[i] = 1'b0;
         end
      end
      if (pop) begin
         live_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = rd_ptr_q + PtrW'(1);
      end
      // Applied after the kill: a same-cycle enqueue is younger than the ALU write.
      if (push) begin
         live_d[wr_ptr_q] = 1'b1;
         wr_ptr_d         = wr_ptr_q + PtrW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      wen_d    = 1'b0;
      wraddr_d = wraddr_q;
      wrdata_d = wrdata_q;
      if (alu_grant) begin
         wen_d    = (alu_rd != 5'd0);
         wraddr_d = alu_rd;
         wrdata_d = alu_data;
      end else if (pop) begin
         wen_d    = live_q[rd_ptr_q];
         wraddr_d = rd_q[rd_ptr_q];
         wrdata_d = data_q[rd_ptr_q];
      end
   end

`ifdef WB_STARVE_GUARD_EN
   localparam int unsigned StW = $clog2(STARVE_MAX + 1);
   logic [StW-1:0] starve_q, starve_d;

   always_comb begin
      starve_d    = starve_q;
      alu_stall_d = 1'b0;
      if (pop || fifo_empty) begin
         starve_d = '0;
      end else if (alu_grant && head_live) begin
         if (starve_q == StW'(STARVE_MAX - 1)) begin
            // This win is number STARVE_MAX: stall the ALU next cycle so the head pops.
            alu_stall_d = 1'b1;
            starve_d    = '0;
         end else begin
            starve_d = starve_q + StW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   assign alu_stall_d = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_q      <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         alu_stall_q <= 1'b0;
         wen_q       <= 1'b0;
         wraddr_q    <= '0;
         wrdata_q    <= '0;
      end else begin
         live_q      <= live_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         alu_stall_q <= alu_stall_d;
         wen_q       <= wen_d;
         wraddr_q    <= wraddr_d;
         wrdata_q    <= wrdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[wr_ptr_q]   <= lsu_rd;
         data_q[wr_ptr_q] <= lsu_data;
      end
   end

   assign alu_stall  = alu_stall_q;
   assign wen        = wen_q;
   assign wraddr     = wraddr_q;
   assign wrdata     = wrdata_q;
   assign fifo_count = count_q;

endmodule
